// File: rtl/dataint_checksum_check.sv
// Receive-side additive checksum checker: sums payload words, compares with the
// trailing checksum word, reports per packet and keeps saturating counters.
module dataint_checksum_check #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LEN_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic [LEN_WIDTH-1:0] i_max_len,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_last,
  output logic                 o_done,
  output logic                 o_pass,
  output logic                 o_fail,
  output logic                 o_len_err,
  output logic [WIDTH-1:0]     o_expected,
  output logic [WIDTH-1:0]     o_received,
  output logic [CNT_WIDTH-1:0] o_pkt_count,
  output logic [CNT_WIDTH-1:0] o_err_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     sum_q, sum_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 lerr_q, lerr_d;
  logic                 pass_q, pass_d;
  logic                 fail_q, fail_d;
  logic                 len_err_q, len_err_d;
  logic [WIDTH-1:0]     exp_q, exp_d;
  logic [WIDTH-1:0]     rcv_q, rcv_d;
  logic [CNT_WIDTH-1:0] pkt_q, pkt_d;
  logic [CNT_WIDTH-1:0] err_q, err_d;
  logic                 accept;
  logic                 finish;
  logic                 pass_c;

  assign accept = i_valid && (state_q != REPORT);

  // Next-state and result computation; results are latched as REPORT is entered.
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    len_d     = len_q;
    lerr_d    = lerr_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    len_err_d = len_err_q;
    exp_d     = exp_q;
    rcv_d     = rcv_q;
    pkt_d     = pkt_q;
    err_d     = err_q;
    finish    = 1'b0;
    pass_c    = (sum_q == i_data) && !lerr_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (i_last) begin
            finish = 1'b1;
          end else if (i_max_len == '0) begin
            lerr_d  = 1'b1;
            state_d = DRAIN;
          end else begin
            sum_d   = i_data;
            len_d   = LEN_WIDTH'(1);
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          if (i_last) begin
            finish = 1'b1;
          end else if (len_q >= i_max_len) begin
            lerr_d  = 1'b1;
            state_d = DRAIN;
          end else begin
            sum_d = sum_q + i_data;
            len_d = len_q + LEN_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (accept && i_last) begin
          finish = 1'b1;
        end
      end
      REPORT: begin
        state_d = IDLE;
        sum_d   = '0;
        len_d   = '0;
        lerr_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d   = REPORT;
      exp_d     = sum_q;
      rcv_d     = i_data;
      pass_d    = pass_c;
      fail_d    = !pass_c;
      len_err_d = lerr_q;
      if (pkt_q != '1) pkt_d = pkt_q + CNT_WIDTH'(1);
      if (!pass_c && (err_q != '1)) err_d = err_q + CNT_WIDTH'(1);
    end

    if (i_clear) begin
      state_d   = IDLE;
      sum_d     = '0;
      len_d     = '0;
      lerr_d    = 1'b0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      len_err_d = 1'b0;
      exp_d     = '0;
      rcv_d     = '0;
      pkt_d     = '0;
      err_d     = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      sum_q     <= '0;
      len_q     <= '0;
      lerr_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      len_err_q <= 1'b0;
      exp_q     <= '0;
      rcv_q     <= '0;
      pkt_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      len_q     <= len_d;
      lerr_q    <= lerr_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      len_err_q <= len_err_d;
      exp_q     <= exp_d;
      rcv_q     <= rcv_d;
      pkt_q     <= pkt_d;
      err_q     <= err_d;
    end
  end

  assign o_ready     = (state_q != REPORT);
  assign o_done      = (state_q == REPORT);
  assign o_pass      = pass_q;
  assign o_fail      = fail_q;
  assign o_len_err   = len_err_q;
  assign o_expected  = exp_q;
  assign o_received  = rcv_q;
  assign o_pkt_count = pkt_q;
  assign o_err_count = err_q;

endmodule

// File: tb/tb_dataint_checksum_check.sv
// Bench for dataint_checksum_check: directed packets with literal expectations
// plus randomized packets checked every cycle against a queue-based model.
module tb_dataint_checksum_check;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_clear;
  logic [7:0]  i_max_len;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        i_last;
  logic        o_ready, o_done, o_pass, o_fail, o_len_err;
  logic [7:0]  o_expected, o_received;
  logic [15:0] o_pkt_count, o_err_count;
  logic        o_ready2, o_done2, o_pass2, o_fail2, o_len_err2;
  logic [7:0]  o_expected2, o_received2;
  logic [1:0]  o_pkt_count2, o_err_count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dataint_checksum_check #(.WIDTH(8), .LEN_WIDTH(8), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(i_clear), .i_max_len(i_max_len),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_last(i_last),
    .o_done(o_done), .o_pass(o_pass), .o_fail(o_fail), .o_len_err(o_len_err),
    .o_expected(o_expected), .o_received(o_received),
    .o_pkt_count(o_pkt_count), .o_err_count(o_err_count)
  );

  dataint_checksum_check #(.WIDTH(8), .LEN_WIDTH(8), .CNT_WIDTH(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(i_clear), .i_max_len(i_max_len),
    .i_valid(i_valid), .o_ready(o_ready2), .i_data(i_data), .i_last(i_last),
    .o_done(o_done2), .o_pass(o_pass2), .o_fail(o_fail2), .o_len_err(o_len_err2),
    .o_expected(o_expected2), .o_received(o_received2),
    .o_pkt_count(o_pkt_count2), .o_err_count(o_err_count2)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: payload words queued per packet, result computed at the checksum beat.
  int q[$];
  bit m_rep, m_pass, m_fail, m_lerr;
  int m_exp, m_rcv, m_pkt, m_err, m_pkt2, m_err2;

  task automatic model_step();
    if (i_clear) begin
      q.delete();
      m_rep = 0; m_pass = 0; m_fail = 0; m_lerr = 0;
      m_exp = 0; m_rcv = 0; m_pkt = 0; m_err = 0; m_pkt2 = 0; m_err2 = 0;
    end else if (m_rep) begin
      m_rep = 0;
    end else if (i_valid) begin
      if (!i_last) begin
        q.push_back(int'(i_data));
      end else begin : finish_pkt
        int n;
        int s;
        n = q.size();
        s = 0;
        for (int k = 0; k < n && k < int'(i_max_len); k++) s += q[k];
        s = s % 256;
        m_lerr = (n > int'(i_max_len));
        m_pass = (s == int'(i_data)) && !m_lerr;
        m_fail = !m_pass;
        m_exp  = s;
        m_rcv  = int'(i_data);
        if (m_pkt < 65535) m_pkt++;
        if (m_pkt2 < 3) m_pkt2++;
        if (!m_pass && m_err < 65535) m_err++;
        if (!m_pass && m_err2 < 3) m_err2++;
        q.delete();
        m_rep = 1;
      end
    end
  endtask

  initial begin
    m_rep = 0; m_pass = 0; m_fail = 0; m_lerr = 0;
    m_exp = 0; m_rcv = 0; m_pkt = 0; m_err = 0; m_pkt2 = 0; m_err2 = 0;
    forever begin
      @(posedge clk);
      if (rst_n) model_step();
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("ready",    int'(o_ready),     int'(!m_rep));
        chk("done",     int'(o_done),      int'(m_rep));
        chk("pass",     int'(o_pass),      int'(m_pass));
        chk("fail",     int'(o_fail),      int'(m_fail));
        chk("len_err",  int'(o_len_err),   int'(m_lerr));
        chk("expected", int'(o_expected),  m_exp);
        chk("received", int'(o_received),  m_rcv);
        chk("pkt_count", int'(o_pkt_count), m_pkt);
        chk("err_count", int'(o_err_count), m_err);
        chk("sat_done", int'(o_done2),     int'(m_rep));
        chk("sat_pkt_count", int'(o_pkt_count2), m_pkt2);
        chk("sat_err_count", int'(o_err_count2), m_err2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_last  = 1'b0;
    tick();
  endtask

  // Offer a beat and hold it until accepted; returns just after the accepting edge.
  task automatic beat(input logic [7:0] d, input logic l);
    bit ok;
    ok = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("handshake_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    i_valid = 1'($urandom % 2);
    i_data  = 8'($urandom);
    i_last  = 1'b0;
    tick();
    i_clear = 1'b0;
    i_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, sum;
    bit aborted;
    logic [7:0] d, ck;
    rst_n = 1'b0; i_clear = 1'b0; i_max_len = 8'd16;
    i_valid = 1'b0; i_data = 8'h00; i_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_ready", int'(o_ready), 1);
    chk("reset_done",  int'(o_done), 0);
    chk("reset_pkt",   int'(o_pkt_count), 0);
    tick();

    beat(8'h10, 0); beat(8'h20, 0); beat(8'h30, 0); beat(8'h60, 1);
    chk("basic_done", int'(o_done), 1);
    chk("basic_ready", int'(o_ready), 0);
    chk("basic_pass", int'(o_pass), 1);
    chk("basic_expected", int'(o_expected), 'h60);
    chk("basic_pkt", int'(o_pkt_count), 1);
    chk("basic_err", int'(o_err_count), 0);
    idle();
    chk("basic_after_done", int'(o_done), 0);
    chk("basic_after_ready", int'(o_ready), 1);

    beat(8'hFF, 0); beat(8'h02, 0); beat(8'h01, 1);
    chk("wrap_pass", int'(o_pass), 1);
    chk("wrap_expected", int'(o_expected), 'h01);
    idle();

    beat(8'h01, 0); beat(8'h02, 0); beat(8'h04, 1);
    chk("mismatch_fail", int'(o_fail), 1);
    chk("mismatch_expected", int'(o_expected), 'h03);
    chk("mismatch_received", int'(o_received), 'h04);
    chk("mismatch_err", int'(o_err_count), 1);
    idle();

    beat(8'h00, 1);
    chk("zero_pass", int'(o_pass), 1);
    idle();
    beat(8'h05, 1);
    chk("zero_fail", int'(o_fail), 1);
    chk("zero_pkt", int'(o_pkt_count), 5);
    idle();

    i_max_len = 8'd2;
    for (int k = 0; k < 4; k++) begin
      beat(8'h01, 0);
      chk("lenovf_ready", int'(o_ready), 1);
    end
    beat(8'h02, 1);
    chk("lenovf_len_err", int'(o_len_err), 1);
    chk("lenovf_fail", int'(o_fail), 1);
    chk("lenovf_expected", int'(o_expected), 'h02);
    idle();
    i_max_len = 8'd16;

    beat(8'h01, 0); beat(8'h01, 1);
    i_valid = 1'b1; i_data = 8'h07; i_last = 1'b1;
    tick();
    chk("bp_n2_done", int'(o_done), 0);
    chk("bp_n2_ready", int'(o_ready), 1);
    tick();
    chk("bp_n3_done", int'(o_done), 1);
    chk("bp_n3_received", int'(o_received), 'h07);
    idle();

    beat(8'h10, 0); beat(8'h20, 0);
    i_clear = 1'b1; i_valid = 1'b1; i_data = 8'h30; i_last = 1'b0;
    tick();
    i_clear = 1'b0; i_valid = 1'b0;
    chk("clear_done", int'(o_done), 0);
    chk("clear_pkt", int'(o_pkt_count), 0);
    chk("clear_err", int'(o_err_count), 0);
    chk("clear_expected", int'(o_expected), 0);
    tick();
    beat(8'h00, 1);
    chk("clear_restart_pass", int'(o_pass), 1);
    chk("clear_restart_pkt", int'(o_pkt_count), 1);
    i_valid = 1'b0;
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    chk("clear_report_pkt", int'(o_pkt_count), 0);

    for (int k = 0; k < 5; k++) begin
      beat(8'h05, 1);
      idle();
    end
    chk("sat_pkt_hold", int'(o_pkt_count2), 3);
    chk("sat_err_hold", int'(o_err_count2), 3);
    chk("wide_err", int'(o_err_count), 5);

    for (int p = 0; p < 300; p++) begin
      if ($urandom % 8 == 0) i_max_len = ($urandom % 2 == 1) ? 8'd16 : 8'($urandom % 6);
      len = int'($urandom % 9);
      sum = 0;
      aborted = 0;
      for (int k = 0; k < len; k++) begin
        if ($urandom % 50 == 0) begin
          do_clear();
          aborted = 1;
          break;
        end
        d = 8'($urandom);
        sum += int'(d);
        beat(d, 0);
        if ($urandom % 4 == 0) idle();
      end
      if (!aborted) begin
        ck = ($urandom % 2 == 1) ? 8'(sum) : 8'($urandom);
        beat(ck, 1);
        if ($urandom % 2 == 1) idle();
      end
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
